// File: rtl/mem_wb_stage_if.sv
// ============================================================================
// Module      : mem_wb_stage_if
// Description : MEM -> WB bus bundle. The master drives the MEM-stage slot and
//               the stall/flush controls; the slave (the WB register) returns
//               the registered write-back fields.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_wb_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              stall;
  logic              flush;
  logic              mem_valid;
  logic              mem_reg_write;
  logic [REG_AW-1:0] mem_rd;
  logic [XLEN-1:0]   mem_result;
  logic [XLEN-1:0]   mem_link_addr;
  logic [XLEN-1:0]   mem_rdata;
  logic [XLEN-1:0]   io_din;
  logic [2:0]        mem_funct3;
  logic [1:0]        wb_src;

  logic              wb_valid;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_result;
  logic              wb_is_io;

  modport master (
    output stall, flush, mem_valid, mem_reg_write, mem_rd, mem_result,
           mem_link_addr, mem_rdata, io_din, mem_funct3, wb_src,
    input  wb_valid, wb_reg_write, wb_rd, wb_result, wb_is_io
  );

  modport slave (
    input  stall, flush, mem_valid, mem_reg_write, mem_rd, mem_result,
           mem_link_addr, mem_rdata, io_din, mem_funct3, wb_src,
    output wb_valid, wb_reg_write, wb_rd, wb_result, wb_is_io
  );
endinterface

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline register. Selects memory or IO load data,
//               extracts and extends byte/half/word loads, picks the
//               write-back value and registers it under rst > flush > stall
//               > load priority.
//               Optional macro MEM_WB_PERF_CNT_EN adds saturating
//               retired_cnt / stall_cnt performance counters.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_wb_stage #(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int IO_ADDR_BIT = 10,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_wb_stage_if.slave       bus
`ifdef MEM_WB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    retired_cnt,
  output logic [CNT_W-1:0]    stall_cnt
`endif
);

  // Byte-lane offset width: 4 lanes at XLEN=32, 8 lanes at XLEN=64.
  localparam int OFF_W = (XLEN == 64) ? 3 : 2;

  logic              is_io;
  logic [XLEN-1:0]   raw;
  logic [OFF_W-1:0]  off;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [XLEN-1:0]   word_sx;
  logic [XLEN-1:0]   word_zx;
  logic [XLEN-1:0]   load_val;
  logic [XLEN-1:0]   wb_next;
  logic              load_en;

  logic              wb_valid_d,     wb_valid_q;
  logic              wb_reg_write_d, wb_reg_write_q;
  logic [REG_AW-1:0] wb_rd_d,        wb_rd_q;
  logic [XLEN-1:0]   wb_result_d,    wb_result_q;
  logic              wb_is_io_d,     wb_is_io_q;

  // Pick the load source and slice the addressed byte and halfword lanes.
  always_comb begin
    is_io     = bus.mem_result[IO_ADDR_BIT];
    raw       = is_io ? bus.io_din : bus.mem_rdata;
    off       = bus.mem_result[OFF_W-1:0];
    lane_byte = raw[{off, 3'b000} +: 8];
    lane_half = raw[{off[OFF_W-1:1], 4'b0000} +: 16];
  end

  // Word loads only narrow the data on a 64-bit datapath; on 32 bits the
  // whole raw word is the result for both LW and LWU.
  generate
    if (XLEN == 64) begin : g_word_x64
      logic [31:0] lane_word;
      assign lane_word = off[OFF_W-1] ? raw[XLEN-1:XLEN-32] : raw[31:0];
      assign word_sx   = {{(XLEN-32){lane_word[31]}}, lane_word};
      assign word_zx   = {{(XLEN-32){1'b0}}, lane_word};
    end else begin : g_word_x32
      assign word_sx = raw;
      assign word_zx = raw;
    end
  endgenerate

  // Extend the selected lane by funct3, then choose the write-back source.
  always_comb begin
    load_val = raw;
    case (bus.mem_funct3)
      3'b000:  load_val = {{(XLEN-8){lane_byte[7]}}, lane_byte};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, lane_byte};
      3'b001:  load_val = {{(XLEN-16){lane_half[15]}}, lane_half};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, lane_half};
      3'b010:  load_val = word_sx;
      3'b110:  load_val = word_zx;
      default: load_val = raw;
    endcase

    wb_next = '0;
    case (bus.wb_src)
      2'd0:    wb_next = bus.mem_result;
      2'd1:    wb_next = load_val;
      2'd2:    wb_next = bus.mem_link_addr;
      default: wb_next = '0;
    endcase
  end

  // Next WB state: reset and flush clear, stall holds, otherwise load.
  always_comb begin
    load_en        = !rst && !bus.flush && !bus.stall;
    wb_valid_d     = wb_valid_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_rd_d        = wb_rd_q;
    wb_result_d    = wb_result_q;
    wb_is_io_d     = wb_is_io_q;
    if (rst || bus.flush) begin
      wb_valid_d     = 1'b0;
      wb_reg_write_d = 1'b0;
      wb_rd_d        = '0;
      wb_result_d    = '0;
      wb_is_io_d     = 1'b0;
    end else if (!bus.stall) begin
      wb_valid_d     = bus.mem_valid;
      // x0 is hard-wired zero, so a write there is suppressed at the port.
      wb_reg_write_d = bus.mem_valid && bus.mem_reg_write && (bus.mem_rd != '0);
      wb_rd_d        = bus.mem_rd;
      wb_result_d    = wb_next;
      wb_is_io_d     = is_io;
    end
  end

  // WB register bank.
  always_ff @(posedge clk) begin
    wb_valid_q     <= wb_valid_d;
    wb_reg_write_q <= wb_reg_write_d;
    wb_rd_q        <= wb_rd_d;
    wb_result_q    <= wb_result_d;
    wb_is_io_q     <= wb_is_io_d;
  end

  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_reg_write = wb_reg_write_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_result    = wb_result_q;
  assign bus.wb_is_io     = wb_is_io_q;

`ifdef MEM_WB_PERF_CNT_EN
  logic [CNT_W-1:0] retired_cnt_d, retired_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d,   stall_cnt_q;

  // Saturating counters: retired on real loads, stalled on held cycles.
  always_comb begin
    retired_cnt_d = retired_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    if (rst) begin
      retired_cnt_d = '0;
      stall_cnt_d   = '0;
    end else begin
      if (load_en && bus.mem_valid && !(&retired_cnt_q))
        retired_cnt_d = retired_cnt_q + CNT_W'(1);
      if (bus.stall && !bus.flush && !(&stall_cnt_q))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    retired_cnt_q <= retired_cnt_d;
    stall_cnt_q   <= stall_cnt_d;
  end

  assign retired_cnt = retired_cnt_q;
  assign stall_cnt   = stall_cnt_q;
`else
  generate
    if (CNT_W > 0) begin : g_no_perf_cnt
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Scoreboard bench for mem_wb_stage at XLEN=32 and XLEN=64.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

  typedef struct {
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [63:0] res;
    logic        io;
  } wb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Stimulus shared by both widths; the 32-bit DUT sees the low halves.
  logic        t_rst, t_stall, t_flush, t_valid, t_rw;
  logic [4:0]  t_rd;
  logic [63:0] t_res, t_link, t_rdata, t_io;
  logic [2:0]  t_f3;
  logic [1:0]  t_src;

  int n_tests = 0;
  int n_fail  = 0;

  mem_wb_stage_if #(.XLEN(32), .REG_AW(5)) if32 ();
  mem_wb_stage_if #(.XLEN(64), .REG_AW(5)) if64 ();

  assign rst                = t_rst;
  assign if32.stall         = t_stall;
  assign if32.flush         = t_flush;
  assign if32.mem_valid     = t_valid;
  assign if32.mem_reg_write = t_rw;
  assign if32.mem_rd        = t_rd;
  assign if32.mem_result    = t_res[31:0];
  assign if32.mem_link_addr = t_link[31:0];
  assign if32.mem_rdata     = t_rdata[31:0];
  assign if32.io_din        = t_io[31:0];
  assign if32.mem_funct3    = t_f3;
  assign if32.wb_src        = t_src;
  assign if64.stall         = t_stall;
  assign if64.flush         = t_flush;
  assign if64.mem_valid     = t_valid;
  assign if64.mem_reg_write = t_rw;
  assign if64.mem_rd        = t_rd;
  assign if64.mem_result    = t_res;
  assign if64.mem_link_addr = t_link;
  assign if64.mem_rdata     = t_rdata;
  assign if64.io_din        = t_io;
  assign if64.mem_funct3    = t_f3;
  assign if64.wb_src        = t_src;

`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0] rc32, sc32, rc64, sc64;
  logic [31:0] m_ret = 32'd0;
  logic [31:0] m_stl = 32'd0;
`endif

  mem_wb_stage #(.XLEN(32), .REG_AW(5), .IO_ADDR_BIT(10), .CNT_W(32)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (if32.slave)
`ifdef MEM_WB_PERF_CNT_EN
    ,
    .retired_cnt (rc32),
    .stall_cnt   (sc32)
`endif
  );

  mem_wb_stage #(.XLEN(64), .REG_AW(5), .IO_ADDR_BIT(10), .CNT_W(32)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (if64.slave)
`ifdef MEM_WB_PERF_CNT_EN
    ,
    .retired_cnt (rc64),
    .stall_cnt   (sc64)
`endif
  );

  wb_t q32[$];
  wb_t q64[$];
  wb_t m32, m64;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference load extraction, written as shifts on a 64-bit container.
  function automatic logic [63:0] extract(input int xlen);
    logic [63:0] mask, raw, sb, sh, sw, r;
    int off;
    mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    raw  = (t_res[10] ? t_io : t_rdata) & mask;
    off  = (xlen == 32) ? int'(t_res[1:0]) : int'(t_res[2:0]);
    sb   = raw >> (8 * off);
    sh   = raw >> (8 * (off & 6));
    sw   = raw >> (8 * (off & 4));
    case (t_f3)
      3'b000:  r = {{56{sb[7]}}, sb[7:0]};
      3'b100:  r = {56'd0, sb[7:0]};
      3'b001:  r = {{48{sh[15]}}, sh[15:0]};
      3'b101:  r = {48'd0, sh[15:0]};
      3'b010:  r = {{32{sw[31]}}, sw[31:0]};
      3'b110:  r = (xlen == 32) ? raw : {32'd0, sw[31:0]};
      default: r = raw;
    endcase
    return r & mask;
  endfunction

  function automatic wb_t model_next(input wb_t cur, input int xlen);
    wb_t n;
    logic [63:0] mask;
    n    = cur;
    mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    if (t_rst || t_flush) begin
      n = '{1'b0, 1'b0, 5'd0, 64'd0, 1'b0};
    end else if (!t_stall) begin
      n.v  = t_valid;
      n.rw = t_valid && t_rw && (t_rd != 5'd0);
      n.rd = t_rd;
      n.io = t_res[10];
      case (t_src)
        2'd0:    n.res = t_res & mask;
        2'd1:    n.res = extract(xlen);
        2'd2:    n.res = t_link & mask;
        default: n.res = 64'd0;
      endcase
    end
    return n;
  endfunction

  // Push expected state for the current inputs, clock once, pop and compare.
  task automatic tick();
    wb_t e;
    m32 = model_next(m32, 32);
    m64 = model_next(m64, 64);
    q32.push_back(m32);
    q64.push_back(m64);
`ifdef MEM_WB_PERF_CNT_EN
    if (t_rst) begin
      m_ret = 32'd0;
      m_stl = 32'd0;
    end else begin
      if (!t_flush && !t_stall && t_valid) m_ret = m_ret + 32'd1;
      if (t_stall && !t_flush)             m_stl = m_stl + 32'd1;
    end
`endif
    @(posedge clk);
    #1;
    if (q32.size() == 0 || q64.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
    end else begin
      e = q32.pop_front();
      check("d32_valid", {63'd0, if32.wb_valid},     {63'd0, e.v});
      check("d32_rw",    {63'd0, if32.wb_reg_write}, {63'd0, e.rw});
      check("d32_rd",    {59'd0, if32.wb_rd},        {59'd0, e.rd});
      check("d32_res",   {32'd0, if32.wb_result},    e.res);
      check("d32_io",    {63'd0, if32.wb_is_io},     {63'd0, e.io});
      e = q64.pop_front();
      check("d64_valid", {63'd0, if64.wb_valid},     {63'd0, e.v});
      check("d64_rw",    {63'd0, if64.wb_reg_write}, {63'd0, e.rw});
      check("d64_rd",    {59'd0, if64.wb_rd},        {59'd0, e.rd});
      check("d64_res",   if64.wb_result,             e.res);
      check("d64_io",    {63'd0, if64.wb_is_io},     {63'd0, e.io});
    end
`ifdef MEM_WB_PERF_CNT_EN
    check("d32_retired", {32'd0, rc32}, {32'd0, m_ret});
    check("d32_stalls",  {32'd0, sc32}, {32'd0, m_stl});
    check("d64_retired", {32'd0, rc64}, {32'd0, m_ret});
    check("d64_stalls",  {32'd0, sc64}, {32'd0, m_stl});
`endif
  endtask

  task automatic randomize_data();
    t_valid = 1'($urandom);
    t_rw    = 1'($urandom);
    t_rd    = 5'($urandom);
    t_res   = {$urandom, $urandom};
    t_link  = {$urandom, $urandom};
    t_rdata = {$urandom, $urandom};
    t_io    = {$urandom, $urandom};
    t_f3    = 3'($urandom);
    t_src   = 2'($urandom);
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [1:0] src, input logic [2:0] f3,
                          input logic [63:0] res, input logic [63:0] rdata, input logic [63:0] io);
    t_rst = 1'b0; t_stall = 1'b0; t_flush = 1'b0;
    t_valid = 1'b1; t_rw = 1'b1; t_rd = rd; t_src = src; t_f3 = f3;
    t_res = res; t_rdata = rdata; t_io = io; t_link = 64'd0;
  endtask

  initial begin
    m32 = '{1'b0, 1'b0, 5'd0, 64'd0, 1'b0};
    m64 = m32;
    t_stall = 1'b0;
    t_flush = 1'b0;

    // Reset with random inputs.
    t_rst = 1'b1;
    randomize_data();
    t_stall = 1'($urandom);
    tick();
    randomize_data();
    tick();
    check("rst_valid", {63'd0, if32.wb_valid}, 64'd0);
    check("rst_res",   {32'd0, if32.wb_result}, 64'd0);

    // LB / LBU sign and zero extension.
    set_load(5'd1, 2'd1, 3'b000, 64'h3, 64'h80FF7F01, 64'd0);
    tick();
    check("lb_res", {32'd0, if32.wb_result}, 64'hFFFF_FF80);
    set_load(5'd1, 2'd1, 3'b100, 64'h3, 64'h80FF7F01, 64'd0);
    tick();
    check("lbu_res", {32'd0, if32.wb_result}, 64'h0000_0080);

    // IO select.
    set_load(5'd2, 2'd1, 3'b010, 64'h400, 64'hDEADBEEF, 64'h12345678);
    tick();
    check("io_res", {32'd0, if32.wb_result}, 64'h1234_5678);
    check("io_flag", {63'd0, if32.wb_is_io}, 64'd1);

    // Stall hold, then stall+flush together.
    set_load(5'd5, 2'd0, 3'b000, 64'h11, 64'd0, 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      randomize_data();
      t_stall = 1'b1;
      tick();
      check("stall_rd",  {59'd0, if32.wb_rd},     64'd5);
      check("stall_res", {32'd0, if32.wb_result}, 64'h11);
    end
    t_flush = 1'b1;
    tick();
    check("sf_valid", {63'd0, if32.wb_valid},     64'd0);
    check("sf_rw",    {63'd0, if32.wb_reg_write}, 64'd0);

    // x0 write suppression, invalid slot, link value.
    set_load(5'd0, 2'd0, 3'b000, 64'h55, 64'd0, 64'd0);
    tick();
    check("x0_rw",  {63'd0, if32.wb_reg_write}, 64'd0);
    check("x0_res", {32'd0, if32.wb_result},    64'h55);
    set_load(5'd7, 2'd0, 3'b000, 64'h66, 64'd0, 64'd0);
    t_valid = 1'b0;
    tick();
    check("inv_rw", {63'd0, if32.wb_reg_write}, 64'd0);
    set_load(5'd1, 2'd2, 3'b000, 64'h0, 64'd0, 64'd0);
    t_link = 64'h104;
    tick();
    check("link_res", {32'd0, if32.wb_result}, 64'h104);

    // XLEN=64 word and halfword extraction.
    set_load(5'd3, 2'd1, 3'b110, 64'h4, 64'h89ABCDEF_01234567, 64'd0);
    tick();
    check("lwu64_res", if64.wb_result, 64'h0000_0000_89AB_CDEF);
    set_load(5'd3, 2'd1, 3'b001, 64'h6, 64'h89ABCDEF_01234567, 64'd0);
    tick();
    check("lh64_res", if64.wb_result, 64'hFFFF_FFFF_FFFF_89AB);

    // Reset asserted while stalled clears the held state.
    set_load(5'd9, 2'd0, 3'b000, 64'hABC, 64'd0, 64'd0);
    tick();
    t_stall = 1'b1;
    t_rst   = 1'b1;
    tick();
    check("rst_stall_res", {32'd0, if32.wb_result}, 64'd0);
    check("rst_stall_rd",  {59'd0, if32.wb_rd},     64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      randomize_data();
      t_rst   = ($urandom_range(0, 31) == 0);
      t_stall = ($urandom_range(0, 3) == 0);
      t_flush = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
